// File: rtl/ttl_timer_pkg.sv
// Shared definitions for the 74x461 timer sequencer: counter mode pin codes and controller states.
package ttl_timer_pkg;

    localparam logic [1:0] MODE_CLEAR = 2'b00;
    localparam logic [1:0] MODE_HOLD  = 2'b01;
    localparam logic [1:0] MODE_LOAD  = 2'b10;
    localparam logic [1:0] MODE_COUNT = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } ttl_state_e;

endpackage

// File: rtl/ttl_tick_prescaler.sv
// Modulo-PRESCALE strobe generator for the timer sequencer; used only when TTL_TIMER_CTL_PRESCALE_EN is defined.
module ttl_tick_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic CLK,
    input  logic CLR_n,
    input  logic restart,
    output logic strobe
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    // restart realigns the strobe so that each count window begins fresh after a (re)load
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign strobe = (cnt == LAST);

endmodule

// File: rtl/ttl_counter_timer_ctl.sv
// Load/count/reload sequencer for one 74x461 presettable counter; optional prescaler under TTL_TIMER_CTL_PRESCALE_EN.
// cmd handshake: a command transfers on a rising CLK edge where cmd_valid && cmd_ready; cmd_ready is high only in IDLE.
module ttl_counter_timer_ctl
    import ttl_timer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int REPW  = 8
`ifdef TTL_TIMER_CTL_PRESCALE_EN
    , parameter int PRESCALE = 4
`endif
) (
    input  logic             CLK,
    input  logic             CLR_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_preset,
    input  logic [REPW-1:0]  cmd_reps,
    input  logic             cmd_abort,
    output logic             ctr_m1,
    output logic             ctr_m0,
    output logic             ctr_ci_n,
    output logic [WIDTH-1:0] ctr_d,
    input  logic [WIDTH-1:0] ctr_q,
    input  logic             ctr_co_n,
    output logic             tick,
    output logic             done,
    output logic             busy,
    output logic [REPW-1:0]  reps_left,
    output logic [2:0]       dbg_state
);

    ttl_state_e       state, nxt_state;
    logic [WIDTH-1:0] preset_q, nxt_preset;
    logic [REPW-1:0]  reps_q, nxt_reps;
    logic [1:0]       mode;
    logic             ci_n, tick_c, done_c, restart, strobe;
    logic             unused_sigs;

`ifdef TTL_TIMER_CTL_PRESCALE_EN
    ttl_tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .CLK     (CLK),
        .CLR_n   (CLR_n),
        .restart (restart),
        .strobe  (strobe)
    );
`else
    assign strobe = 1'b1;
`endif

    assign unused_sigs = ^{ctr_q, restart};

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            state    <= IDLE;
            preset_q <= '0;
            reps_q   <= '0;
        end else begin
            state    <= nxt_state;
            preset_q <= nxt_preset;
            reps_q   <= nxt_reps;
        end
    end

    always_comb begin
        nxt_state  = state;
        nxt_preset = preset_q;
        nxt_reps   = reps_q;
        mode       = MODE_HOLD;
        ci_n       = 1'b1;
        tick_c     = 1'b0;
        done_c     = 1'b0;
        restart    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    nxt_preset = cmd_preset;
                    nxt_reps   = cmd_reps;
                    nxt_state  = LOAD;
                end
            end
            LOAD: begin
                mode      = MODE_LOAD;
                restart   = 1'b1;
                nxt_state = RUN;
            end
            RUN: begin
                mode = MODE_COUNT;
                ci_n = !strobe;
                // terminal count: reload P rather than letting the counter wrap to zero
                if (!ctr_co_n && strobe) begin
                    tick_c = 1'b1;
                    if (reps_q != '0) begin
                        nxt_reps = reps_q - 1'b1;
                    end
                    if (reps_q == REPW'(1)) begin
                        mode      = MODE_HOLD;
                        nxt_state = DONE;
                    end else begin
                        mode    = MODE_LOAD;
                        restart = 1'b1;
                    end
                end
            end
            DONE: begin
                done_c    = 1'b1;
                nxt_state = IDLE;
            end
            ABORT: begin
                mode      = MODE_CLEAR;
                nxt_reps  = '0;
                nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
        // abort freezes the counter this cycle; the clear happens in ABORT
        if (cmd_abort && state != IDLE) begin
            nxt_state = ABORT;
            nxt_reps  = reps_q;
            mode      = MODE_HOLD;
            ci_n      = 1'b1;
            tick_c    = 1'b0;
            done_c    = 1'b0;
            restart   = 1'b0;
        end
    end

    // reset forces CLEAR on the mode pins without waiting for a clock
    assign ctr_m1    = CLR_n & mode[1];
    assign ctr_m0    = CLR_n & mode[0];
    assign ctr_ci_n  = !CLR_n | ci_n;
    assign ctr_d     = (CLR_n && mode == MODE_LOAD) ? preset_q : '0;
    assign tick      = CLR_n & tick_c;
    assign done      = CLR_n & done_c;
    assign busy      = CLR_n && (state != IDLE);
    assign cmd_ready = CLR_n && (state == IDLE);
    assign reps_left = reps_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_ttl_counter_timer_ctl.sv
// Bench: timer sequencer driving a behavioural 74x461 counter, checked against a closed-form period model.
module tb_ttl_counter_timer_ctl;

`ifdef TTL_TIMER_CTL_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    logic       CLK = 1'b0;
    logic       CLR_n;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_preset = 8'h00;
    logic [7:0] cmd_reps = 8'h00;
    logic       cmd_abort = 1'b0;
    logic       ctr_m1, ctr_m0, ctr_ci_n;
    logic [7:0] ctr_d, ctr_q;
    logic       ctr_co_n;
    logic       tick, done, busy;
    logic [7:0] reps_left;
    logic [2:0] dbg_state;
    logic [1:0] mode_w;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

`ifdef TTL_TIMER_CTL_PRESCALE_EN
    ttl_counter_timer_ctl #(.WIDTH(8), .REPW(8), .PRESCALE(PS)) dut (
`else
    ttl_counter_timer_ctl #(.WIDTH(8), .REPW(8)) dut (
`endif
        .CLK(CLK), .CLR_n(CLR_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_preset(cmd_preset), .cmd_reps(cmd_reps), .cmd_abort(cmd_abort),
        .ctr_m1(ctr_m1), .ctr_m0(ctr_m0), .ctr_ci_n(ctr_ci_n), .ctr_d(ctr_d),
        .ctr_q(ctr_q), .ctr_co_n(ctr_co_n), .tick(tick), .done(done), .busy(busy),
        .reps_left(reps_left), .dbg_state(dbg_state)
    );

    // 74x461 model: 00 async clear, 01 hold, 10 sync load, 11 count when CI_n low
    assign mode_w = {ctr_m1, ctr_m0};
    wire clr_async = (mode_w == 2'b00);
    logic [7:0] q_r;
    always @(posedge CLK or posedge clr_async) begin
        if (clr_async) q_r <= 8'h00;
        else if (mode_w == 2'b10) q_r <= ctr_d;
        else if (mode_w == 2'b11 && !ctr_ci_n) q_r <= q_r + 8'h01;
    end
    assign ctr_q    = q_r;
    assign ctr_co_n = !(q_r == 8'hFF);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic test_reset();
        CLR_n = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_mode", 32'(mode_w), 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ci_n", 32'(ctr_ci_n), 32'h1);
        chk("rst_d", 32'(ctr_d), 32'h0);
        chk("rst_reps_left", 32'(reps_left), 32'h0);
        chk("rst_q", 32'(ctr_q), 32'h0);
        @(posedge CLK); #1;
        CLR_n = 1'b1;
        @(negedge CLK);
        chk("post_rst_ready", 32'(cmd_ready), 32'h1);
        chk("post_rst_busy", 32'(busy), 32'h0);
        chk("post_rst_mode", 32'(mode_w), 32'h1);
        chk("post_rst_q", 32'(ctr_q), 32'h0);
    endtask

    // One command from offer to return to IDLE. abort_t < 0: run to completion.
    // Model: with period pp = (256-P)*PS, at RUN cycle t Q = P + (t mod pp)/PS, tick when t mod pp == pp-1.
    task automatic run_cmd(input string name, input logic [7:0] p, input logic [7:0] reps, input int abort_t);
        int pp, rl_e;
        logic [7:0] q_e;
        logic tick_e;
        int tk;
        bit fin, aborted;
        pp = (256 - int'(p)) * PS;
        @(posedge CLK); #1;
        cmd_valid = 1'b1; cmd_preset = p; cmd_reps = reps;
        @(negedge CLK);
        chk({name, "_ready"}, 32'(cmd_ready), 32'h1);
        @(posedge CLK); #1;
        cmd_valid = 1'b0; cmd_preset = 8'($urandom); cmd_reps = 8'($urandom);
        @(negedge CLK);
        chk({name, "_load_mode"}, 32'(mode_w), 32'h2);
        chk({name, "_load_d"}, 32'(ctr_d), 32'(p));
        chk({name, "_load_busy"}, 32'(busy), 32'h1);
        chk({name, "_load_reps"}, 32'(reps_left), 32'(reps));
        tk = 0; fin = 1'b0; aborted = 1'b0;
        for (int t = 0; t < 4000 && !fin; t++) begin
            @(posedge CLK); #1;
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_abort = (t == abort_t);
            @(negedge CLK);
            q_e    = p + 8'((t % pp) / PS);
            tick_e = ((t % pp) == pp - 1);
            rl_e   = (reps == 0) ? 0 : int'(reps) - t / pp;
            chk({name, "_q"}, 32'(ctr_q), 32'(q_e));
            chk({name, "_ready_busy"}, 32'(cmd_ready), 32'h0);
            chk({name, "_done_early"}, 32'(done), 32'h0);
            if (t == abort_t) begin
                chk({name, "_abort_tick"}, 32'(tick), 32'h0);
                chk({name, "_abort_noreload"}, 32'(mode_w == 2'b10), 32'h0);
                fin = 1'b1; aborted = 1'b1;
            end else begin
                chk({name, "_tick"}, 32'(tick), 32'(tick_e));
                chk({name, "_reps_left"}, 32'(reps_left), 32'(rl_e));
                if (tick_e) tk++;
                if (tick_e && reps != 0 && tk == int'(reps)) fin = 1'b1;
            end
        end
        if (!fin) chk({name, "_timeout"}, 32'h1, 32'h0);
        @(posedge CLK); #1;
        cmd_valid = 1'b0; cmd_abort = 1'b0;
        @(negedge CLK);
        if (aborted) begin
            chk({name, "_abort_mode"}, 32'(mode_w), 32'h0);
            chk({name, "_abort_q"}, 32'(ctr_q), 32'h0);
            chk({name, "_abort_done"}, 32'(done), 32'h0);
        end else begin
            chk({name, "_done"}, 32'(done), 32'h1);
            chk({name, "_done_q"}, 32'(ctr_q), 32'hFF);
            chk({name, "_done_mode"}, 32'(mode_w), 32'h1);
            chk({name, "_done_reps"}, 32'(reps_left), 32'h0);
        end
        @(negedge CLK);
        chk({name, "_idle_busy"}, 32'(busy), 32'h0);
        chk({name, "_idle_ready"}, 32'(cmd_ready), 32'h1);
        chk({name, "_idle_done"}, 32'(done), 32'h0);
        chk({name, "_idle_q"}, 32'(ctr_q), aborted ? 32'h0 : 32'hFF);
    endtask

    task automatic test_abort_idle();
        @(posedge CLK); #1;
        cmd_abort = 1'b1;
        @(negedge CLK);
        chk("idle_abort_mode", 32'(mode_w), 32'h1);
        @(posedge CLK); #1;
        cmd_abort = 1'b0;
        @(negedge CLK);
        chk("idle_abort_busy", 32'(busy), 32'h0);
        chk("idle_abort_ready", 32'(cmd_ready), 32'h1);
        chk("idle_abort_done", 32'(done), 32'h0);
    endtask

    task automatic test_reset_mid_run();
        @(posedge CLK); #1;
        cmd_valid = 1'b1; cmd_preset = 8'h80; cmd_reps = 8'd2;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        repeat (6) @(posedge CLK);
        #2;
        CLR_n = 1'b0;
        #1;
        chk("midrst_mode", 32'(mode_w), 32'h0);
        chk("midrst_q", 32'(ctr_q), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_ready", 32'(cmd_ready), 32'h0);
        @(posedge CLK); #1;
        CLR_n = 1'b1;
        @(negedge CLK);
        chk("midrst_idle_ready", 32'(cmd_ready), 32'h1);
        chk("midrst_idle_mode", 32'(mode_w), 32'h1);
        chk("midrst_idle_q", 32'(ctr_q), 32'h0);
    endtask

    task automatic test_random();
        logic [7:0] p, r;
        for (int i = 0; i < 4; i++) begin
            p = 8'($urandom_range(8'hE0, 8'hFF));
            r = 8'($urandom_range(1, 4));
            run_cmd("rand", p, r, -1);
        end
    endtask

    initial begin
        test_reset();
        run_cmd("p_fd_r2", 8'hFD, 8'd2, -1);
        run_cmd("p_ff_r3", 8'hFF, 8'd3, -1);
        run_cmd("free_run", 8'hF0, 8'd0, 5 * 16 * PS);
        run_cmd("abort_tc", 8'hFC, 8'd5, 2 * 4 * PS - 1);
        run_cmd("p_fe_r1", 8'hFE, 8'd1, -1);
        test_abort_idle();
        test_random();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
